io_port_ctrl: RTL and testbench

- Memory-mapped controller for the microcontroller's 32-bit bidirectional port_io pins.
- Per-bit direction and output registers, synchronised input sampling, and rising-edge interrupt detection with pending, mask and priority-ID registers.
- Sits on the MIPS data bus as a peripheral. The buttons on port_io[3:0] reach software through this block by polling or by interrupt.

---
 rtl/io_port_pkg.sv | 14 +
 rtl/io_port_ctrl_if.sv | 15 +
 rtl/io_sync_edge.sv | 33 +++
 rtl/io_port_ctrl.sv | 92 +++++++++
 tb/tb_io_port_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_port_pkg.sv
// Shared constants for the io_port_ctrl peripheral: register word indices
// and the bit positions of the ID register.
package io_port_pkg;
    localparam int BUS_W = 32;

    localparam logic [2:0] REG_DIR  = 3'd0;
    localparam logic [2:0] REG_OUT  = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_IEN  = 3'd3;
    localparam logic [2:0] REG_PEND = 3'd4;
    localparam logic [2:0] REG_ID   = 3'd5;

    localparam int ID_VALID_BIT = 31;
endpackage

// File: rtl/io_port_ctrl_if.sv
// CPU-side data bus of the port controller: chip-select, direction, word
// index, write/read data and the interrupt line back to the CPU.
interface io_port_ctrl_if;
    import io_port_pkg::*;

    logic             ce;
    logic             wr;
    logic [2:0]       addr;
    logic [BUS_W-1:0] data_in;
    logic [BUS_W-1:0] data_out;
    logic             irq;

    modport master (output ce, wr, addr, data_in, input  data_out, irq);
    modport slave  (input  ce, wr, addr, data_in, output data_out, irq);
endinterface

// File: rtl/io_sync_edge.sv
// Multi-stage input synchroniser for the port pins followed by a "previous"
// flop, producing the synchronised value and a one-cycle rising-edge vector.
module io_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             rst_sync,
    input  logic [WIDTH-1:0] i_pins,
    output logic [WIDTH-1:0] o_sync,
    output logic [WIDTH-1:0] o_rise
);
    logic [WIDTH-1:0] r_stage [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;

    // NOTE: the stage array is a handful of flops, not a RAM, so every entry is
    // cleared on reset; otherwise stale values could fake a rise after reset.
    always_ff @(posedge sys_clk) begin
        if (rst_sync) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_stage[s] <= '0;
            r_prev <= '0;
        end else begin
            // NOTE: <= lets each stage take its neighbour's old value; with =
            // the whole chain would collapse into a single flop.
            r_stage[0] <= i_pins;
            for (int s = 1; s < SYNC_STAGES; s++) r_stage[s] <= r_stage[s-1];
            r_prev <= r_stage[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];
    assign o_rise = r_stage[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped GPIO port: direction/output registers, tristate pin drive,
// synchronised inputs, rising-edge pending flags with mask and priority ID.
module io_port_ctrl
    import io_port_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             sys_clk,
    input  logic             rst_sync,
    io_port_ctrl_if.slave    bus,
    inout  wire  [WIDTH-1:0] port_io
);
    logic [WIDTH-1:0] r_dir, r_out, r_ien, r_pend;
    logic [WIDTH-1:0] w_in, w_rise, w_clr, w_active;
    logic             w_wr, w_rd, w_id_valid;
    logic [4:0]       w_id_idx;
    logic [BUS_W-1:0] w_rdata;

    assign w_wr = bus.ce & bus.wr;
    assign w_rd = bus.ce & ~bus.wr;

    io_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .sys_clk  (sys_clk),
        .rst_sync (rst_sync),
        .i_pins   (port_io),
        .o_sync   (w_in),
        .o_rise   (w_rise)
    );

    for (genvar g = 0; g < WIDTH; g++) begin : g_pin
        assign port_io[g] = r_dir[g] ? r_out[g] : 1'bz;
    end

    assign w_clr = (w_wr && bus.addr == REG_PEND) ? bus.data_in[WIDTH-1:0] : '0;

    always_ff @(posedge sys_clk) begin
        if (rst_sync) begin
            r_dir  <= '0;
            r_out  <= '0;
            r_ien  <= '0;
            r_pend <= '0;
        end else begin
            if (w_wr && bus.addr == REG_DIR) r_dir <= bus.data_in[WIDTH-1:0];
            if (w_wr && bus.addr == REG_OUT) r_out <= bus.data_in[WIDTH-1:0];
            if (w_wr && bus.addr == REG_IEN) r_ien <= bus.data_in[WIDTH-1:0];
            // A rise landing on the same edge as its clear keeps the flag set;
            // pins driven as outputs never raise a flag.
            r_pend <= (r_pend & ~w_clr) | (w_rise & ~r_dir);
        end
    end

    assign w_active = r_pend & r_ien;
    assign bus.irq  = |w_active;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_id_valid = 1'b0;
        w_id_idx   = '0;
        // Scanning downward leaves the lowest active index as the final winner.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (w_active[i]) begin
                w_id_valid = 1'b1;
                w_id_idx   = 5'(i);
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_rd) begin
            case (bus.addr)
                REG_DIR:  w_rdata = BUS_W'(r_dir);
                REG_OUT:  w_rdata = BUS_W'(r_out);
                REG_IN:   w_rdata = BUS_W'(w_in);
                REG_IEN:  w_rdata = BUS_W'(r_ien);
                REG_PEND: w_rdata = BUS_W'(r_pend);
                REG_ID: begin
                    w_rdata[ID_VALID_BIT] = w_id_valid;
                    w_rdata[4:0]          = w_id_idx;
                end
                default: w_rdata = '0;
            endcase
        end
    end

    assign bus.data_out = w_rdata;
endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed register/pin scenarios, then
// randomized bus and pin traffic compared with a pin-history reference model.
module tb_io_port_ctrl;
    import io_port_pkg::*;

    localparam int WIDTH       = 32;
    localparam int SYNC_STAGES = 2;

    logic              sys_clk = 1'b0;
    logic              rst_sync;
    wire  [WIDTH-1:0]  port_io;
    logic [WIDTH-1:0]  tb_val;
    logic [WIDTH-1:0]  tb_en;

    io_port_ctrl_if bus ();

    io_port_ctrl #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .sys_clk  (sys_clk),
        .rst_sync (rst_sync),
        .bus      (bus),
        .port_io  (port_io)
    );

    always #10 sys_clk = ~sys_clk;

    // The bench drives exactly the pins the model says are inputs.
    for (genvar g = 0; g < WIDTH; g++) begin : g_tb_pin
        assign port_io[g] = tb_en[g] ? tb_val[g] : 1'bz;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus the history of pin values seen
    // at each clock edge (newest first).
    logic [31:0] m_dir, m_out, m_ien, m_pend;
    logic [31:0] m_samples[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset_history();
        m_samples.delete();
        repeat (SYNC_STAGES + 1) m_samples.push_back(32'h0);
    endtask

    // A pin is seen in IN SYNC_STAGES edges after it was sampled; a flag is
    // raised on the edge after IN first shows a 0->1 step on an input pin.
    task automatic model_step();
        logic [31:0] pins, rise, clr;
        pins = (m_dir & m_out) | (~m_dir & tb_val);
        rise = m_samples[SYNC_STAGES-1] & ~m_samples[SYNC_STAGES];
        if (rst_sync) begin
            m_dir  = '0;
            m_out  = '0;
            m_ien  = '0;
            m_pend = '0;
            model_reset_history();
        end else begin
            clr    = (bus.ce && bus.wr && bus.addr == REG_PEND) ? bus.data_in : 32'h0;
            m_pend = (m_pend & ~clr) | (rise & ~m_dir);
            if (bus.ce && bus.wr) begin
                case (bus.addr)
                    REG_DIR: m_dir = bus.data_in;
                    REG_OUT: m_out = bus.data_in;
                    REG_IEN: m_ien = bus.data_in;
                    default: ;
                endcase
            end
            m_samples.push_front(pins);
            void'(m_samples.pop_back());
        end
    endtask

    function automatic logic [31:0] exp_id();
        logic [31:0] act;
        act = m_pend & m_ien;
        for (int i = 0; i < WIDTH; i++) begin
            if (act[i]) return 32'h8000_0000 | 32'(i);
        end
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            REG_DIR:  return m_dir;
            REG_OUT:  return m_out;
            REG_IN:   return m_samples[SYNC_STAGES-1];
            REG_IEN:  return m_ien;
            REG_PEND: return m_pend;
            REG_ID:   return exp_id();
            default:  return 32'h0;
        endcase
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
        tb_en = ~m_dir;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.ce      = 1'b1;
        bus.wr      = 1'b1;
        bus.addr    = a;
        bus.data_in = d;
        tick();
        bus.ce = 1'b0;
        bus.wr = 1'b0;
    endtask

    task automatic rd_exp(input string tag, input logic [2:0] a, input logic [31:0] exp);
        bus.ce   = 1'b1;
        bus.wr   = 1'b0;
        bus.addr = a;
        #1;
        check(tag, bus.data_out, exp);
        bus.ce = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] a);
        rd_exp(tag, a, exp_read(a));
    endtask

    task automatic check_irq(input string tag, input logic exp);
        check(tag, 32'(bus.irq), 32'(exp));
    endtask

    initial begin
        logic [2:0] ra;
        int         op;

        bus.ce = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.data_in = '0;
        m_dir = '0; m_out = '0; m_ien = '0; m_pend = '0;
        model_reset_history();
        tb_val = '0;
        tb_en  = '1;

        // Reset held three cycles, with a DIR write fighting it.
        rst_sync    = 1'b1;
        bus.ce      = 1'b1;
        bus.wr      = 1'b1;
        bus.addr    = REG_DIR;
        bus.data_in = 32'hFFFF_FFFF;
        repeat (3) tick();
        bus.ce = 1'b0; bus.wr = 1'b0;
        rst_sync = 1'b0;
        for (int a = 0; a < 8; a++) rd_exp("reset_read", 3'(a), 32'h0);
        check_irq("reset_irq", 1'b0);

        // All pins released after reset: bench-driven values arrive intact.
        tb_val = 32'h5A3C_96E1;
        repeat (3) tick();
        rd_exp("in_after_reset", REG_IN, 32'h5A3C_96E1);
        rd_exp("pend_all_rises", REG_PEND, 32'h5A3C_96E1);
        check_irq("irq_masked_all", 1'b0);
        bus.addr = REG_PEND;
        #1 check("idle_data_out", bus.data_out, 32'h0);
        bus.ce = 1'b1; bus.wr = 1'b1; bus.addr = REG_IN; bus.data_in = 32'h0;
        #1 check("write_data_out", bus.data_out, 32'h0);
        bus.ce = 1'b0; bus.wr = 1'b0;
        bus_write(REG_PEND, 32'hFFFF_FFFF);
        rd_exp("pend_w1c_all", REG_PEND, 32'h0);

        // Output drive and read-back through the synchroniser.
        tb_val = '0;
        repeat (2) tick();
        bus_write(REG_DIR, 32'hFFFF_FFF0);
        bus_write(REG_OUT, 32'hA5A5_A5A0);
        check("pins_driven", {4'h0, port_io[31:4]}, 32'h0A5A_5A5A);
        tick();
        rd("in_one_cycle", REG_IN);
        tick();
        rd_exp("in_two_cycles", REG_IN, 32'hA5A5_A5A0);
        rd_exp("dir_readback", REG_DIR, 32'hFFFF_FFF0);
        tick();
        rd_exp("no_pend_on_outputs", REG_PEND, 32'h0);
        bus_write(REG_DIR, 32'h0);
        repeat (3) tick();
        rd_exp("no_false_edge", REG_PEND, 32'h0);
        bus_write(REG_OUT, 32'h0);

        // Button on bit 3 with its interrupt enabled.
        bus_write(REG_IEN, 32'h8);
        tb_val = 32'h8;
        repeat (2) tick();
        rd_exp("btn_pend_early", REG_PEND, 32'h0);
        check_irq("btn_irq_early", 1'b0);
        tick();
        rd_exp("btn_pend", REG_PEND, 32'h8);
        check_irq("btn_irq", 1'b1);
        rd_exp("btn_id", REG_ID, 32'h8000_0003);
        repeat (2) tick();
        tb_val = '0;
        bus_write(REG_PEND, 32'h8);
        check_irq("btn_irq_cleared", 1'b0);

        // Two simultaneous rises, then W1C walks the priority.
        bus_write(REG_IEN, 32'hF);
        tb_val = 32'h6;
        repeat (3) tick();
        tb_val = '0;
        rd_exp("dual_pend", REG_PEND, 32'h6);
        rd_exp("dual_id", REG_ID, 32'h8000_0001);
        bus_write(REG_PEND, 32'h2);
        rd_exp("w1c_pend", REG_PEND, 32'h4);
        rd_exp("w1c_id", REG_ID, 32'h8000_0002);
        bus_write(REG_PEND, 32'h4);
        check_irq("w1c_irq_low", 1'b0);
        rd_exp("w1c_id_empty", REG_ID, 32'h0);

        // Clear lands on the same edge as the set: set wins.
        tb_val = 32'h1;
        repeat (2) tick();
        bus_write(REG_PEND, 32'h1);
        tb_val = '0;
        rd_exp("collision_pend", REG_PEND, 32'h1);
        bus_write(REG_PEND, 32'h1);
        rd_exp("collision_cleared", REG_PEND, 32'h0);

        // Masked interrupt still records the edge.
        bus_write(REG_IEN, 32'h0);
        tb_val = 32'h1;
        repeat (3) tick();
        tb_val = '0;
        rd_exp("masked_pend", REG_PEND, 32'h1);
        check_irq("masked_irq", 1'b0);
        rd_exp("masked_id", REG_ID, 32'h0);
        bus_write(REG_PEND, 32'h1);

        // Bit 0 as output toggled high: read back, no flag.
        bus_write(REG_DIR, 32'h1);
        bus_write(REG_OUT, 32'h1);
        repeat (3) tick();
        rd_exp("out_bit_readback", REG_IN, 32'h1);
        rd_exp("out_bit_no_pend", REG_PEND, 32'h0);
        bus_write(REG_OUT, 32'h0);
        bus_write(REG_DIR, 32'h0);

        // Reserved words.
        bus_write(3'd7, 32'hFFFF_FFFF);
        rd_exp("reserved7", 3'd7, 32'h0);
        rd_exp("reserved6", 3'd6, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) tb_val = $urandom;
            op = int'($urandom_range(0, 7));
            if (op < 4) begin
                bus.ce      = 1'b1;
                bus.wr      = 1'b1;
                bus.addr    = 3'($urandom_range(0, 7));
                bus.data_in = $urandom;
            end
            tick();
            bus.ce = 1'b0;
            bus.wr = 1'b0;
            ra = 3'($urandom_range(0, 7));
            rd("rand_read", ra);
            check_irq("rand_irq", |(m_pend & m_ien));
            if (n % 16 == 0) rd("rand_id", REG_ID);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
